// File: rtl/if_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_if
//  Description : Instruction-memory request/ack port between IF and memory.
//  Revision    : 1.0 - initial release
// ============================================================================
interface if_fetch_if;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_ack_i;
    logic [31:0] inst_rdata_i;

    modport master (
        output inst_req_o,
        output inst_addr_o,
        input  inst_ack_i,
        input  inst_rdata_i
    );

    modport slave (
        input  inst_req_o,
        input  inst_addr_o,
        output inst_ack_i,
        output inst_rdata_i
    );
endinterface
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch
//  Description : IF stage: owns the PC, fetches over req/ack, handles stall,
//                flush, delayed branch redirect and misaligned-PC delivery.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic [5:0]  stall,
    input  wire logic        flush,
    input  wire logic [31:0] new_pc,
    input  wire logic        branch_flag_i,
    input  wire logic [31:0] branch_target_i,
    if_fetch_if.master       mem,
    output logic      [31:0] if_pc,
    output logic      [31:0] if_inst,
    output logic             if_pc_invalid,
    output logic             stallreq_if
);

    localparam logic [31:0] C_PC_STEP = 32'(PC_STEP);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        br_pend_q, br_pend_d;
    logic [31:0] br_target_q, br_target_d;
    logic [31:0] inst_buf_q, inst_buf_d;
    logic        inv_buf_q, inv_buf_d;
    logic [31:0] drop_addr_q, drop_addr_d;

    logic        w_misaligned;
    logic        w_delivered;
    logic        w_advance;
    logic [31:0] w_adv_pc;
    logic        stall_unused;

    assign stall_unused = ^stall[5:1];
    assign w_misaligned = |pc_q[1:0];
    assign w_adv_pc     = branch_flag_i ? branch_target_i :
                          br_pend_q     ? br_target_q     :
                                          pc_q + C_PC_STEP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            br_pend_q   <= 1'b0;
            br_target_q <= 32'h0;
            inst_buf_q  <= 32'h0;
            inv_buf_q   <= 1'b0;
            drop_addr_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            br_pend_q   <= br_pend_d;
            br_target_q <= br_target_d;
            inst_buf_q  <= inst_buf_d;
            inv_buf_q   <= inv_buf_d;
            drop_addr_q <= drop_addr_d;
        end
    end

    // Output decode; a misaligned PC is delivered at once without touching memory.
    always_comb begin
        mem.inst_req_o  = 1'b0;
        mem.inst_addr_o = 32'h0;
        if_pc           = 32'h0;
        if_inst         = 32'h0;
        if_pc_invalid   = 1'b0;
        stallreq_if     = 1'b0;
        w_delivered     = 1'b0;
        case (state_q)
            S_REQ: begin
                if_pc = pc_q;
                if (w_misaligned) begin
                    if_pc_invalid = 1'b1;
                    w_delivered   = 1'b1;
                end else begin
                    mem.inst_req_o  = 1'b1;
                    mem.inst_addr_o = pc_q;
                    stallreq_if     = !mem.inst_ack_i;
                    if (mem.inst_ack_i) begin
                        if_inst     = mem.inst_rdata_i;
                        w_delivered = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if_pc         = pc_q;
                if_inst       = inst_buf_q;
                if_pc_invalid = inv_buf_q;
            end
            S_DROP: begin
                mem.inst_req_o  = 1'b1;
                mem.inst_addr_o = drop_addr_q;
                stallreq_if     = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        br_pend_d   = br_pend_q;
        br_target_d = br_target_q;
        inst_buf_d  = inst_buf_q;
        inv_buf_d   = inv_buf_q;
        drop_addr_d = drop_addr_q;
        w_advance   = 1'b0;

        if (flush) begin
            pc_d      = new_pc;
            br_pend_d = 1'b0;
            // An un-acked request cannot be withdrawn, so wait it out in S_DROP.
            if (state_q == S_REQ && !w_misaligned && !mem.inst_ack_i) begin
                state_d     = S_DROP;
                drop_addr_d = pc_q;
            end else if (state_q == S_DROP && !mem.inst_ack_i) begin
                state_d = S_DROP;
            end else begin
                state_d = S_REQ;
            end
        end else begin
            case (state_q)
                S_IDLE: state_d = S_REQ;
                S_REQ: begin
                    if (w_delivered) begin
                        if (stall[0]) begin
                            inst_buf_d = w_misaligned ? 32'h0 : mem.inst_rdata_i;
                            inv_buf_d  = w_misaligned;
                            state_d    = S_HOLD;
                        end else begin
                            w_advance = 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall[0]) begin
                        w_advance = 1'b1;
                        state_d   = S_REQ;
                    end
                end
                S_DROP: begin
                    if (mem.inst_ack_i) state_d = S_REQ;
                end
                default: state_d = S_IDLE;
            endcase

            if (w_advance) begin
                pc_d      = w_adv_pc;
                br_pend_d = 1'b0;
            end else if (branch_flag_i) begin
                br_pend_d   = 1'b1;
                br_target_d = branch_target_i;
            end
        end
    end

endmodule
`default_nettype wire
